// File: rtl/wb_sram_responder.sv
// wb_sram_responder: Wishbone B4 classic responder in front of a word-addressed SRAM.
// A request is captured and decoded in IDLE, optionally held for a fixed number of
// wait states, then terminated with exactly one ack or err pulse. Misaligned or
// out-of-window accesses terminate with err and never touch the array.
module wb_sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int          AW           = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LAST    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          hit_q, hit_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dat_o_q, dat_o_d;
  logic          mem_wr;
  logic [31:0]   off;

  logic [31:0] mem [DEPTH_WORDS];

  assign off      = wb_adr_i - ADDR_BASE;
  assign wb_dat_o = dat_o_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

  // Next-state logic: capture and decode in IDLE, count wait states, terminate in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_o_d = 32'd0;
    mem_wr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          hit_d   = (off < WINDOW_BYTES) && (wb_adr_i[1:0] == 2'b00);
          idx_d   = off[AW+1:2];
          wdat_d  = wb_dat_i;
          sel_d   = wb_sel_i;
          we_d    = wb_we_i;
          cnt_d   = 4'd0;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!(wb_cyc_i && wb_stb_i)) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (hit_q) begin
          ack_d = 1'b1;
          if (we_q) mem_wr = 1'b1;
          else      dat_o_d = mem[idx_q];
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured request and registered bus outputs; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_o_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_o_q <= dat_o_d;
    end
  end

  // SRAM byte-lane write on the RESP edge; contents are not reset and a reset edge blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_q[n]) mem[idx_q][8*n +: 8] <= wdat_q[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_responder.sv
// tb_wb_sram_responder: directed checks of wb_sram_responder with 0, 1 and 3 wait states.
// Three instances share clock and reset; index 0 -> WAIT_STATES=0, 1 -> 1, 2 -> 3.
module tb_wb_sram_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;

  logic [31:0] adr   [3];
  logic [31:0] dat_i [3];
  logic [31:0] dat_o [3];
  logic        we    [3];
  logic [3:0]  sel   [3];
  logic        cyc   [3];
  logic        stb   [3];
  logic        ack   [3];
  logic        err   [3];

  int   compareCount  = 0;
  int   mismatchCount = 0;
  logic sawResp;
  int   k;
  logic [31:0] t5Vals [4];

  always #5 clk = ~clk;

  wb_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .wb_adr_i(adr[0]), .wb_dat_i(dat_i[0]), .wb_dat_o(dat_o[0]),
    .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]));

  wb_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .wb_adr_i(adr[1]), .wb_dat_i(dat_i[1]), .wb_dat_o(dat_o[1]),
    .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]));

  wb_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .wb_adr_i(adr[2]), .wb_dat_i(dat_i[2]), .wb_dat_o(dat_o[2]),
    .wb_we_i(we[2]), .wb_sel_i(sel[2]), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]),
    .wb_ack_o(ack[2]), .wb_err_o(err[2]));

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request on one instance's bus.
  task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] s);
    adr[d]   = a;
    dat_i[d] = wd;
    sel[d]   = s;
    we[d]    = w;
    cyc[d]   = 1'b1;
    stb[d]   = 1'b1;
  endtask

  // Return one instance's bus to idle.
  task automatic idleBus(input int d);
    adr[d]   = 32'd0;
    dat_i[d] = 32'd0;
    sel[d]   = 4'd0;
    we[d]    = 1'b0;
    cyc[d]   = 1'b0;
    stb[d]   = 1'b0;
  endtask

  // One full transfer; lat counts rising edges from the request edge to the termination edge.
  task automatic doTransfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] s, output logic gotAck, output logic gotErr,
                            output logic [31:0] rdata, output int lat);
    gotAck = 1'b0;
    gotErr = 1'b0;
    rdata  = 32'd0;
    lat    = -1;
    @(negedge clk);
    applyStimulus(d, w, a, wd, s);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        dat_i[d] = ~wd;
        sel[d]   = ~s;
      end
      if (ack[d] || err[d]) begin
        gotAck = ack[d];
        gotErr = err[d];
        rdata  = dat_o[d];
        lat    = n - 1;
        break;
      end
    end
    idleBus(d);
  endtask

  // Transfer plus checks of termination kind, read data, latency and the idle cycle after.
  task automatic xfer(input string tag, input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s, input logic expAck,
                      input logic [31:0] expData, input int expLat);
    logic        gotAck;
    logic        gotErr;
    logic [31:0] rdata;
    int          lat;
    doTransfer(d, w, a, wd, s, gotAck, gotErr, rdata, lat);
    checkOutput({tag, ".ack"}, 32'(gotAck), 32'(expAck));
    checkOutput({tag, ".err"}, 32'(gotErr), 32'(!expAck));
    checkOutput({tag, ".dat"}, rdata, expData);
    checkOutput({tag, ".lat"}, 32'(lat), 32'(expLat));
    @(negedge clk);
    checkOutput({tag, ".after_resp"}, {30'd0, ack[d], err[d]}, 32'd0);
    checkOutput({tag, ".after_dat"}, dat_o[d], 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) idleBus(d);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset.resp%0d", d), {30'd0, ack[d], err[d]}, 32'd0);
      checkOutput($sformatf("reset.dat%0d", d), dat_o[d], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Full-word write then read back, one wait state.
    xfer("t1.wr", 1, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1, 32'd0, 2);
    xfer("t1.rd", 1, 1'b0, BASE + 32'h10, 32'd0, 4'b0000, 1'b1, 32'hDEADBEEF, 2);

    // Partial lanes 0 and 2.
    xfer("t2.wr", 1, 1'b1, BASE + 32'h10, 32'h11223344, 4'b0101, 1'b1, 32'd0, 2);
    xfer("t2.rd", 1, 1'b0, BASE + 32'h10, 32'd0, 4'b1111, 1'b1, 32'hDE22BE44, 2);

    // No lanes enabled: acked, nothing changes.
    xfer("t2.sel0", 1, 1'b1, BASE + 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1, 32'd0, 2);

    // Out-of-window, misaligned and below-base accesses.
    xfer("t3.oow", 1, 1'b0, BASE + 32'(DEPTH * 4), 32'd0, 4'b1111, 1'b0, 32'd0, 2);
    xfer("t3.mis", 1, 1'b0, BASE + 32'h2, 32'd0, 4'b1111, 1'b0, 32'd0, 2);
    xfer("t3.miswr", 1, 1'b1, BASE + 32'h12, 32'h00000000, 4'b1111, 1'b0, 32'd0, 2);
    xfer("t3.below", 1, 1'b1, BASE - 32'h4, 32'h00000000, 4'b1111, 1'b0, 32'd0, 2);
    xfer("t3.oowwr", 1, 1'b1, BASE + 32'(DEPTH * 4) + 32'h10, 32'h0, 4'b1111, 1'b0, 32'd0, 2);
    xfer("t3.rd", 1, 1'b0, BASE + 32'h10, 32'd0, 4'b1111, 1'b1, 32'hDE22BE44, 2);
    xfer("t3.last", 1, 1'b1, BASE + 32'(DEPTH * 4) - 32'h4, 32'h76543210, 4'b1111, 1'b1, 32'd0, 2);
    xfer("t3.lastrd", 1, 1'b0, BASE + 32'(DEPTH * 4) - 32'h4, 32'd0, 4'b1111, 1'b1, 32'h76543210, 2);

    // Three wait states: strobe dropped one cycle into a write aborts it.
    xfer("t4.pre", 2, 1'b1, BASE + 32'h20, 32'hAAAA5555, 4'b1111, 1'b1, 32'd0, 4);
    @(negedge clk);
    applyStimulus(2, 1'b1, BASE + 32'h20, 32'hCAFEF00D, 4'b1111);
    @(negedge clk);
    idleBus(2);
    sawResp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack[2] || err[2]) sawResp = 1'b1;
    end
    checkOutput("t4.abort", 32'(sawResp), 32'd0);
    xfer("t4.rd", 2, 1'b0, BASE + 32'h20, 32'd0, 4'b1111, 1'b1, 32'hAAAA5555, 4);

    // Zero wait states: four back-to-back reads with strobe held high.
    t5Vals[0] = 32'h01020304;
    t5Vals[1] = 32'hA5A5F0F0;
    t5Vals[2] = 32'h13579BDF;
    t5Vals[3] = 32'hFEDCBA98;
    for (int i = 0; i < 4; i++)
      xfer($sformatf("t5.wr%0d", i), 0, 1'b1, BASE + 32'h40 + 32'(4 * i), t5Vals[i], 4'b1111,
           1'b1, 32'd0, 1);
    @(negedge clk);
    applyStimulus(0, 1'b0, BASE + 32'h40, 32'd0, 4'b1111);
    k = 0;
    for (int n = 1; n <= 20 && k < 4; n++) begin
      @(negedge clk);
      if (ack[0] || err[0]) begin
        checkOutput($sformatf("t5.rd%0d.ack", k), 32'(ack[0]), 32'd1);
        checkOutput($sformatf("t5.rd%0d.dat", k), dat_o[0], t5Vals[k]);
        checkOutput($sformatf("t5.rd%0d.cycle", k), 32'(n), 32'(2 * (k + 1)));
        k++;
        adr[0] = BASE + 32'h40 + 32'(4 * k);
      end
    end
    idleBus(0);
    checkOutput("t5.count", 32'(k), 32'd4);
    @(negedge clk);

    // Reset in the wait state of a write: no termination, word unchanged, bus usable after.
    xfer("t6.pre", 1, 1'b1, BASE + 32'h30, 32'h5A5A5A5A, 4'b1111, 1'b1, 32'd0, 2);
    @(negedge clk);
    applyStimulus(1, 1'b1, BASE + 32'h30, 32'h0BADF00D, 4'b1111);
    @(negedge clk);
    rst = 1'b1;
    idleBus(1);
    sawResp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ack[1] || err[1]) sawResp = 1'b1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack[1] || err[1]) sawResp = 1'b1;
    end
    checkOutput("t6.noresp", 32'(sawResp), 32'd0);
    xfer("t6.rd", 1, 1'b0, BASE + 32'h30, 32'd0, 4'b1111, 1'b1, 32'h5A5A5A5A, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
